// File: rtl/sha256_padder.sv
// SHA-256 message padder: packs 32-bit big-endian words into 512-bit blocks,
// appends the 0x80 marker, zero fill and 64-bit bit length, and hands blocks to the engine.
`timescale 1ns/1ps
module sha256_padder (
    input  logic         clk_100mhz,
    input  logic         rst_i,
    input  logic [31:0]  data_i,
    input  logic         data_valid_i,
    input  logic         data_last_i,
    input  logic [2:0]   data_bytes_i,
    output logic         data_ready_o,
    input  logic         eng_ready_i,
    output logic         blk_start_o,
    output logic [511:0] blk_o,
    output logic         blk_last_o,
    output logic         busy_o
);

    localparam logic [1:0] S_FILL = 2'd0;
    localparam logic [1:0] S_PAD  = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

    logic [1:0]   r_state;
    logic [31:0]  r_buf [16];
    logic [4:0]   r_wcnt;
    logic [63:0]  r_bitlen;
    logic [4:0]   r_mpos;
    logic         r_marker_pending;
    logic         r_need_len;
    logic         r_final;
    logic [1:0]   r_holdoff;
    logic [511:0] r_blk;
    logic         r_start;
    logic         r_last;
    logic         r_busy;

    logic [2:0]   w_nbytes;
    logic [31:0]  w_word;
    logic [511:0] w_blk;
    logic         w_accept;
    logic         w_send;

    assign data_ready_o = (r_state == S_FILL) && (r_wcnt < 5'd16);
    assign w_accept     = data_valid_i && data_ready_o;
    assign w_send       = (r_state == S_SEND) && eng_ready_i && (r_holdoff == 2'd0);

    assign blk_start_o  = r_start;
    assign blk_o        = r_blk;
    assign blk_last_o   = r_last;
    assign busy_o       = r_busy;

    // Number of valid bytes in the offered word (non-last words are always full)
    always_comb begin
        if (!data_last_i) begin
            w_nbytes = 3'd4;
        end else if (data_bytes_i > 3'd4) begin
            w_nbytes = 3'd4;
        end else begin
            w_nbytes = data_bytes_i;
        end
    end

    // Zero the invalid tail bytes and drop the 0x80 marker right after the last valid byte
    always_comb begin
        w_word = data_i;
        for (int k = 0; k < 4; k++) begin
            if (3'(k) < w_nbytes) begin
                w_word[31-8*k -: 8] = data_i[31-8*k -: 8];
            end else if (3'(k) == w_nbytes) begin
                w_word[31-8*k -: 8] = 8'h80;
            end else begin
                w_word[31-8*k -: 8] = 8'h00;
            end
        end
    end

    // Flatten the word buffer into the engine block, word 0 at the top
    always_comb begin
        w_blk = 512'd0;
        for (int k = 0; k < 16; k++) begin
            w_blk[511-32*k -: 32] = r_buf[k];
        end
    end

    // Padder state machine, buffer and output registers
    always_ff @(posedge clk_100mhz) begin
        if (rst_i) begin
            r_state          <= S_FILL;
            r_wcnt           <= 5'd0;
            r_bitlen         <= 64'd0;
            r_mpos           <= 5'd0;
            r_marker_pending <= 1'b0;
            r_need_len       <= 1'b0;
            r_final          <= 1'b0;
            r_holdoff        <= 2'd0;
            r_blk            <= 512'd0;
            r_start          <= 1'b0;
            r_last           <= 1'b0;
            r_busy           <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                r_buf[k] <= 32'h0000_0000;
            end
        end else begin
            r_start <= 1'b0;
            r_last  <= 1'b0;
            // holdoff hides the engine's ready staying high one cycle after a start
            if (r_holdoff != 2'd0) begin
                r_holdoff <= r_holdoff - 2'd1;
            end else begin
                r_holdoff <= r_holdoff;
            end

            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        r_buf[r_wcnt[3:0]] <= w_word;
                        r_wcnt             <= r_wcnt + 5'd1;
                        r_bitlen           <= r_bitlen + {58'd0, w_nbytes, 3'b000};
                        r_busy             <= 1'b1;
                        if (data_last_i) begin
                            if (w_nbytes == 3'd4) begin
                                r_mpos           <= r_wcnt + 5'd1;
                                r_marker_pending <= 1'b1;
                            end else begin
                                r_mpos <= r_wcnt;
                            end
                            r_state <= S_PAD;
                        end else if (r_wcnt == 5'd15) begin
                            r_state <= S_SEND;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end
                S_PAD: begin
                    if (r_marker_pending && (r_mpos <= 5'd15)) begin
                        r_buf[r_mpos[3:0]] <= 32'h8000_0000;
                        r_marker_pending   <= 1'b0;
                    end
                    if (r_mpos <= 5'd13) begin
                        r_buf[14] <= r_bitlen[63:32];
                        r_buf[15] <= r_bitlen[31:0];
                        r_final   <= 1'b1;
                    end else begin
                        r_final    <= 1'b0;
                        r_need_len <= 1'b1;
                    end
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (w_send) begin
                        r_blk     <= w_blk;
                        r_start   <= 1'b1;
                        r_last    <= r_final;
                        r_wcnt    <= 5'd0;
                        r_holdoff <= 2'd2;
                        for (int k = 0; k < 16; k++) begin
                            r_buf[k] <= 32'h0000_0000;
                        end
                        if (r_need_len) begin
                            r_need_len <= 1'b0;
                            r_mpos     <= 5'd0;
                            r_state    <= S_PAD;
                        end else if (r_final) begin
                            r_final          <= 1'b0;
                            r_marker_pending <= 1'b0;
                            r_bitlen         <= 64'd0;
                            r_busy           <= 1'b0;
                            r_state          <= S_FILL;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Self-checking bench for sha256_padder: random and directed messages are compared
// block-by-block against a byte-level SHA-256 padding model.
`timescale 1ns/1ps
module tb_sha256_padder;

    logic         clk;
    logic         rst_i;
    logic [31:0]  data_i;
    logic         data_valid_i;
    logic         data_last_i;
    logic [2:0]   data_bytes_i;
    logic         data_ready_o;
    logic         eng_ready_i;
    logic         blk_start_o;
    logic [511:0] blk_o;
    logic         blk_last_o;
    logic         busy_o;

    logic         eng_idle;
    logic         eng_hold;
    logic [7:0]   msg_q [$];
    logic [512:0] exp_q [$];
    logic [512:0] got_q [$];
    int           n_cmp;
    int           n_fail;

    assign eng_ready_i = eng_idle && !eng_hold;

    sha256_padder dut (
        .clk_100mhz   (clk),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .data_last_i  (data_last_i),
        .data_bytes_i (data_bytes_i),
        .data_ready_o (data_ready_o),
        .eng_ready_i  (eng_ready_i),
        .blk_start_o  (blk_start_o),
        .blk_o        (blk_o),
        .blk_last_o   (blk_last_o),
        .busy_o       (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Engine model: goes busy for a random time after each start pulse
    initial begin
        eng_idle = 1'b1;
        forever begin
            @(negedge clk);
            if (blk_start_o === 1'b1) begin
                eng_idle = 1'b0;
                repeat ($urandom_range(0, 6)) @(negedge clk);
                eng_idle = 1'b1;
            end
        end
    end

    // Block monitor
    always @(negedge clk) begin
        if (blk_start_o === 1'b1) got_q.push_back({blk_last_o, blk_o});
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: pad the byte message per SHA-256 and cut it into 64-byte blocks
    task automatic build_expected();
        logic [7:0]   pad [$];
        logic [63:0]  bits;
        logic [511:0] b;
        int           nblk;
        pad  = msg_q;
        bits = 64'(msg_q.size()) * 64'd8;
        pad.push_back(8'h80);
        while ((pad.size() % 64) != 56) pad.push_back(8'h00);
        for (int k = 0; k < 8; k++) pad.push_back(bits[63-8*k -: 8]);
        nblk = pad.size() / 64;
        for (int i = 0; i < nblk; i++) begin
            b = 512'd0;
            for (int k = 0; k < 64; k++) b[511-8*k -: 8] = pad[i*64+k];
            exp_q.push_back({(i == nblk-1) ? 1'b1 : 1'b0, b});
        end
    endtask

    task automatic put_word(input logic [31:0] d, input logic last, input logic [2:0] bf, input bit gap);
        int t;
        t = 0;
        @(negedge clk);
        if (gap) begin
            data_valid_i = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        data_i       = d;
        data_last_i  = last;
        data_bytes_i = bf;
        data_valid_i = 1'b1;
        while (data_ready_o !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            n_cmp++;
            n_fail++;
            $error("FAIL word_accept_timeout: observed ready=%b expected 1", data_ready_o);
        end
        @(posedge clk);
    endtask

    task automatic feed(input bit rnd_gap);
        int          len;
        int          nw;
        int          nb;
        logic [31:0] d;
        logic [2:0]  bf;
        logic        last;
        len = msg_q.size();
        nw  = (len == 0) ? 1 : (len + 3) / 4;
        build_expected();
        for (int w = 0; w < nw; w++) begin
            d    = $urandom;
            last = (w == nw - 1);
            for (int k = 0; k < 4; k++)
                if (w*4 + k < len) d[31-8*k -: 8] = msg_q[w*4+k];
            nb = last ? (len - 4*w) : 4;
            if (!last)        bf = 3'($urandom_range(0, 7));
            else if (nb == 4) bf = 3'($urandom_range(4, 7));
            else              bf = 3'(nb);
            put_word(d, last, bf, rnd_gap && ($urandom_range(0, 3) == 0));
            if (w == 0) begin
                #1;
                check("busy_after_first_word", {511'd0, busy_o}, 512'd1);
            end
        end
        @(negedge clk);
        data_valid_i = 1'b0;
        data_last_i  = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        int n;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 3000) begin
            @(negedge clk);
            t++;
        end
        repeat (20) @(negedge clk);
        check({tag, "_block_count"}, 512'(got_q.size()), 512'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_blk%0d", tag, i), got_q[i][511:0], exp_q[i][511:0]);
            check($sformatf("%s_last%0d", tag, i), {511'd0, got_q[i][512]}, {511'd0, exp_q[i][512]});
        end
        check({tag, "_busy_idle"}, {511'd0, busy_o}, 512'd0);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic rand_msg(input int len);
        msg_q.delete();
        for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {511'd0, data_ready_o}, 512'd1);
        check({tag, "_start"}, {511'd0, blk_start_o}, 512'd0);
        check({tag, "_last"},  {511'd0, blk_last_o}, 512'd0);
        check({tag, "_busy"},  {511'd0, busy_o}, 512'd0);
        check({tag, "_blk"},   blk_o, 512'd0);
    endtask

    logic [511:0] blk_prev;
    int           n_prev;

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        eng_hold     = 1'b0;
        rst_i        = 1'b1;
        data_i       = 32'd0;
        data_valid_i = 1'b0;
        data_last_i  = 1'b0;
        data_bytes_i = 3'd0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;
        check_reset_outputs("reset");

        // "abc"
        msg_q = '{8'h61, 8'h62, 8'h63};
        feed(1'b0);
        repeat (6) @(negedge clk);
        check("abc_const", blk_o, {32'h6162_6380, 448'd0, 32'h0000_0018});
        drain("abc");

        // empty, 55 / 56 / 60 / 62 / 64 byte boundaries
        msg_q.delete();
        feed(1'b0);
        drain("empty");
        rand_msg(55); feed(1'b0); drain("len55");
        rand_msg(56); feed(1'b0); drain("len56");
        rand_msg(60); feed(1'b0); drain("len60");
        rand_msg(62); feed(1'b0); drain("len62");
        rand_msg(64); feed(1'b0); drain("len64");

        // backpressure with a full block waiting
        eng_hold = 1'b1;
        blk_prev = blk_o;
        rand_msg(64);
        feed(1'b0);
        n_prev = got_q.size();
        repeat (10) @(negedge clk);
        check("bp_no_start", 512'(got_q.size()), 512'(n_prev));
        check("bp_ready_low", {511'd0, data_ready_o}, 512'd0);
        check("bp_blk_held", blk_o, blk_prev);
        eng_hold = 1'b0;
        @(negedge clk);
        check("bp_start_after_ready", {511'd0, blk_start_o}, 512'd1);
        drain("bp");

        // reset in the middle of a block
        for (int w = 0; w < 7; w++) put_word(32'($urandom), 1'b0, 3'd4, 1'b0);
        @(negedge clk);
        data_valid_i = 1'b0;
        rst_i        = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check_reset_outputs("midrst");
        repeat (20) @(negedge clk);
        check("midrst_no_start", 512'(got_q.size()), 512'd0);
        msg_q = '{8'h61, 8'h62, 8'h63};
        feed(1'b0);
        repeat (6) @(negedge clk);
        check("abc2_const", blk_o, {32'h6162_6380, 448'd0, 32'h0000_0018});
        drain("abc2");

        // random messages with random input gaps
        for (int r = 0; r < 12; r++) begin
            rand_msg($urandom_range(0, 150));
            feed(1'b1);
            drain($sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
